instr_dispatch: RTL and testbench

Sits on the pop side of the instruction queue, between the control unit and the three execution units: load/store, RAM/DMA and arithmetic. It buffers queued instruction entries in a FIFO. Each entry carries a superscalar copy count, and the block expands it into individual copies, issuing one copy per cycle in program order to the unit selected by the instruction type. For each copy it advances the cache and main-memory addresses by per-entry strides, so the execution units receive ready-to-use addresses.

---
 rtl/instr_dispatch.sv | 146 ++++++++++++++
 tb/tb_instr_dispatch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
// Instruction dispatch: buffers queued entries in a FIFO, expands each entry into its
// superscalar copies and issues one copy per cycle, with strided addresses, to one execution unit.
module instr_dispatch #(
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int LOG_DEPTH             = 3,
  parameter int ADDR_W                = 18
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_type,
  input  logic [13:0]                      in_payload,
  input  logic [LOG_SUPERSCALAR_WIDTH-1:0] in_copies_m1,
  input  logic [ADDR_W-1:0]                in_cache_addr,
  input  logic [ADDR_W-1:0]                in_cache_stride,
  input  logic [ADDR_W-1:0]                in_main_addr,
  input  logic [ADDR_W-1:0]                in_main_stride,
  output logic                             ld_st_valid,
  input  logic                             ld_st_ready,
  output logic                             ram_valid,
  input  logic                             ram_ready,
  output logic                             arith_valid,
  input  logic                             arith_ready,
  output logic [13:0]                      out_payload,
  output logic [ADDR_W-1:0]                out_cache_addr,
  output logic [ADDR_W-1:0]                out_main_addr,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] out_copy_idx,
  output logic [LOG_DEPTH:0]               count,
  output logic                             err_loop
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef struct packed {
    logic [1:0]                       typ;
    logic [13:0]                      payload;
    logic [LOG_SUPERSCALAR_WIDTH-1:0] copies_m1;
    logic [ADDR_W-1:0]                cache_addr;
    logic [ADDR_W-1:0]                cache_stride;
    logic [ADDR_W-1:0]                main_addr;
    logic [ADDR_W-1:0]                main_stride;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t                           mem [DEPTH];
  entry_t                           in_entry, head;
  logic [LOG_DEPTH-1:0]             wr_ptr, rd_ptr;
  state_t                           state;
  logic [1:0]                       cur_type;
  logic [LOG_SUPERSCALAR_WIDTH-1:0] cur_copies_m1;
  logic [ADDR_W-1:0]                cur_cache_stride, cur_main_stride;
  logic                             sel_ready, hs, last, not_empty, push, push_fifo, pop;

  always_comb begin
    in_entry              = '0;
    in_entry.typ          = in_type;
    in_entry.payload      = in_payload;
    in_entry.copies_m1    = in_copies_m1;
    in_entry.cache_addr   = in_cache_addr;
    in_entry.cache_stride = in_cache_stride;
    in_entry.main_addr    = in_main_addr;
    in_entry.main_stride  = in_main_stride;
  end

  assign head      = mem[rd_ptr];
  assign in_ready  = (count < (LOG_DEPTH+1)'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = in_valid && in_ready;
  assign push_fifo = push && (in_type != 2'd3);

  always_comb begin
    sel_ready = 1'b0;
    case (cur_type)
      2'd0:    sel_ready = ld_st_ready;
      2'd1:    sel_ready = ram_ready;
      2'd2:    sel_ready = arith_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign hs   = (state == ISSUE) && sel_ready;
  assign last = (out_copy_idx == cur_copies_m1);
  // Reload from the FIFO either out of IDLE or straight after the last copy (no bubble).
  assign pop  = not_empty && ((state == IDLE) || (hs && last));

  always_ff @(posedge clk) begin
    if (push_fifo) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      err_loop         <= 1'b0;
      ld_st_valid      <= 1'b0;
      ram_valid        <= 1'b0;
      arith_valid      <= 1'b0;
      out_payload      <= '0;
      out_cache_addr   <= '0;
      out_main_addr    <= '0;
      out_copy_idx     <= '0;
      cur_type         <= '0;
      cur_copies_m1    <= '0;
      cur_cache_stride <= '0;
      cur_main_stride  <= '0;
    end else begin
      if (push && (in_type == 2'd3)) err_loop <= 1'b1;
      if (push_fifo) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({push_fifo, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        state            <= ISSUE;
        cur_type         <= head.typ;
        cur_copies_m1    <= head.copies_m1;
        cur_cache_stride <= head.cache_stride;
        cur_main_stride  <= head.main_stride;
        out_payload      <= head.payload;
        out_cache_addr   <= head.cache_addr;
        out_main_addr    <= head.main_addr;
        out_copy_idx     <= '0;
        ld_st_valid      <= (head.typ == 2'd0);
        ram_valid        <= (head.typ == 2'd1);
        arith_valid      <= (head.typ == 2'd2);
      end else if (hs) begin
        if (!last) begin
          out_copy_idx   <= out_copy_idx + 1'b1;
          out_cache_addr <= out_cache_addr + cur_cache_stride;
          out_main_addr  <= out_main_addr + cur_main_stride;
        end else begin
          state       <= IDLE;
          ld_st_valid <= 1'b0;
          ram_valid   <= 1'b0;
          arith_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: copy expansion, FIFO full/stall, back-to-back, wrap, loop error, reset.
module tb_instr_dispatch;
  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_type = '0;
  logic [13:0] in_payload = '0;
  logic [2:0]  in_copies_m1 = '0;
  logic [17:0] in_cache_addr = '0, in_cache_stride = '0, in_main_addr = '0, in_main_stride = '0;
  logic        ld_st_valid, ram_valid, arith_valid;
  logic        ld_st_ready = 1'b0, ram_ready = 1'b0, arith_ready = 1'b0;
  logic [13:0] out_payload;
  logic [17:0] out_cache_addr, out_main_addr;
  logic [2:0]  out_copy_idx;
  logic [3:0]  count;
  logic        err_loop;
  int tests = 0, fails = 0;

  instr_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_payload(in_payload), .in_copies_m1(in_copies_m1), .in_cache_addr(in_cache_addr),
    .in_cache_stride(in_cache_stride), .in_main_addr(in_main_addr), .in_main_stride(in_main_stride),
    .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready), .ram_valid(ram_valid), .ram_ready(ram_ready),
    .arith_valid(arith_valid), .arith_ready(arith_ready), .out_payload(out_payload),
    .out_cache_addr(out_cache_addr), .out_main_addr(out_main_addr), .out_copy_idx(out_copy_idx),
    .count(count), .err_loop(err_loop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [13:0] p, input logic [2:0] cm1,
                      input logic [17:0] ca, input logic [17:0] cs,
                      input logic [17:0] ma, input logic [17:0] ms);
    in_valid = 1'b1; in_type = t; in_payload = p; in_copies_m1 = cm1;
    in_cache_addr = ca; in_cache_stride = cs; in_main_addr = ma; in_main_stride = ms;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2; step(); step();
    tests++; if ({ld_st_valid, ram_valid, arith_valid} !== 3'b000) begin fails++; $display("FAIL reset_valid got %b want 000", {ld_st_valid, ram_valid, arith_valid}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if ({out_payload, out_cache_addr, out_main_addr, out_copy_idx} !== '0) begin fails++; $display("FAIL reset_outputs got %h want 0", {out_payload, out_cache_addr, out_main_addr, out_copy_idx}); end
    tests++; if ({count, err_loop} !== 5'd0) begin fails++; $display("FAIL reset_count_err got %h want 0", {count, err_loop}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_arith_copies();
    arith_ready = 1'b1;
    push(2'd2, 14'h1234, 3'd3, 18'h00100, 18'h4, 18'h00200, 18'h10);
    tests++; if (arith_valid !== 1'b0 || count !== 4'd1) begin fails++; $display("FAIL arith_latency got valid=%b count=%0d want 0/1", arith_valid, count); end
    step();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (arith_valid !== 1'b1 || out_copy_idx !== 3'(k) || out_cache_addr !== 18'h100 + 18'(4*k) ||
          out_main_addr !== 18'h200 + 18'(16*k) || out_payload !== 14'h1234) begin
        fails++;
        $display("FAIL arith_copy%0d got v=%b idx=%0d ca=%h ma=%h p=%h want 1/%0d/%h/%h/1234", k, arith_valid,
                 out_copy_idx, out_cache_addr, out_main_addr, out_payload, k, 18'h100 + 18'(4*k), 18'h200 + 18'(16*k));
      end
      step();
    end
    tests++; if ({ld_st_valid, ram_valid, arith_valid} !== 3'b000 || count !== 4'd0) begin fails++; $display("FAIL arith_idle got v=%b count=%0d want 000/0", {ld_st_valid, ram_valid, arith_valid}, count); end
    arith_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    int bad = 0;
    ld_st_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(2'd0, 14'(i), 3'd0, 18'(i), 18'h0, 18'(i), 18'h0);
    tests++; if (in_ready !== 1'b0 || count !== 4'd8) begin fails++; $display("FAIL full_level got in_ready=%b count=%0d want 0/8", in_ready, count); end
    push(2'd0, 14'd99, 3'd0, 18'h0, 18'h0, 18'h0, 18'h0);
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_reject got count=%0d want 8", count); end
    for (int c = 0; c < 10; c++) begin
      if (ld_st_valid !== 1'b1 || out_payload !== 14'd0 || out_copy_idx !== 3'd0 || out_cache_addr !== 18'd0) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad); end
    ld_st_ready = 1'b1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_pop_in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (ld_st_valid !== 1'b1 || out_payload !== 14'(i) || out_cache_addr !== 18'(i)) begin
        fails++; $display("FAIL drain%0d got v=%b p=%0d want 1/%0d", i, ld_st_valid, out_payload, i);
      end
      step();
    end
    tests++; if (ld_st_valid !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL drain_end got v=%b count=%0d want 0/0", ld_st_valid, count); end
  endtask

  task automatic test_back_to_back();
    ram_ready = 1'b1; ld_st_ready = 1'b1;
    push(2'd1, 14'h0AA, 3'd1, 18'h10, 18'h1, 18'h20, 18'h2);
    push(2'd0, 14'h0BB, 3'd0, 18'h30, 18'h0, 18'h40, 18'h0);
    tests++; if ({ld_st_valid, ram_valid} !== 2'b01 || out_copy_idx !== 3'd0 || out_payload !== 14'h0AA) begin fails++; $display("FAIL b2b_ram0 got v=%b idx=%0d p=%h want 01/0/0aa", {ld_st_valid, ram_valid}, out_copy_idx, out_payload); end
    step();
    tests++; if ({ld_st_valid, ram_valid} !== 2'b01 || out_copy_idx !== 3'd1 || out_cache_addr !== 18'h11) begin fails++; $display("FAIL b2b_ram1 got v=%b idx=%0d ca=%h want 01/1/11", {ld_st_valid, ram_valid}, out_copy_idx, out_cache_addr); end
    step();
    tests++; if ({ld_st_valid, ram_valid} !== 2'b10 || out_payload !== 14'h0BB || out_cache_addr !== 18'h30) begin fails++; $display("FAIL b2b_ldst got v=%b p=%h ca=%h want 10/0bb/30", {ld_st_valid, ram_valid}, out_payload, out_cache_addr); end
    step();
    tests++; if ({ld_st_valid, ram_valid, arith_valid} !== 3'b000) begin fails++; $display("FAIL b2b_idle got %b want 000", {ld_st_valid, ram_valid, arith_valid}); end
    ram_ready = 1'b0; ld_st_ready = 1'b0;
  endtask

  task automatic test_wrap();
    arith_ready = 1'b1;
    push(2'd2, 14'h0C0, 3'd1, 18'h3FFFE, 18'h3, 18'h3FFFF, 18'h3FFFF);
    step();
    tests++; if (out_cache_addr !== 18'h3FFFE || out_main_addr !== 18'h3FFFF) begin fails++; $display("FAIL wrap_copy0 got ca=%h ma=%h want 3fffe/3ffff", out_cache_addr, out_main_addr); end
    step();
    tests++; if (out_cache_addr !== 18'h00001 || out_main_addr !== 18'h3FFFE || out_copy_idx !== 3'd1) begin fails++; $display("FAIL wrap_copy1 got ca=%h ma=%h idx=%0d want 00001/3fffe/1", out_cache_addr, out_main_addr, out_copy_idx); end
    step();
    arith_ready = 1'b0;
  endtask

  task automatic test_loop();
    ld_st_ready = 1'b1; ram_ready = 1'b1; arith_ready = 1'b1;
    push(2'd3, 14'h3FFF, 3'd0, 18'h0, 18'h0, 18'h0, 18'h0);
    tests++; if (err_loop !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL loop_err got err=%b count=%0d want 1/0", err_loop, count); end
    step(); step();
    tests++; if (err_loop !== 1'b1 || {ld_st_valid, ram_valid, arith_valid} !== 3'b000) begin fails++; $display("FAIL loop_sticky got err=%b v=%b want 1/000", err_loop, {ld_st_valid, ram_valid, arith_valid}); end
    ld_st_ready = 1'b0; ram_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    arith_ready = 1'b1;
    push(2'd2, 14'h0DD, 3'd7, 18'h0, 18'h1, 18'h0, 18'h1);
    push(2'd2, 14'h0EE, 3'd0, 18'h0, 18'h0, 18'h0, 18'h0);
    step(); step();
    tests++; if (arith_valid !== 1'b1 || out_copy_idx !== 3'd2 || count !== 4'd1) begin fails++; $display("FAIL mid_setup got v=%b idx=%0d count=%0d want 1/2/1", arith_valid, out_copy_idx, count); end
    #2 reset = 1'b0;
    #1;
    tests++; if ({ld_st_valid, ram_valid, arith_valid} !== 3'b000 || count !== 4'd0 || err_loop !== 1'b0) begin fails++; $display("FAIL mid_async got v=%b count=%0d err=%b want 000/0/0", {ld_st_valid, ram_valid, arith_valid}, count, err_loop); end
    tests++; if (out_copy_idx !== 3'd0 || out_cache_addr !== 18'd0) begin fails++; $display("FAIL mid_outputs got idx=%0d ca=%h want 0/0", out_copy_idx, out_cache_addr); end
    #1 reset = 1'b1;
    step(); step(); step();
    tests++; if ({ld_st_valid, ram_valid, arith_valid} !== 3'b000 || count !== 4'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_idle got v=%b count=%0d in_ready=%b want 000/0/1", {ld_st_valid, ram_valid, arith_valid}, count, in_ready); end
    arith_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith_copies();
    test_full_stall();
    test_back_to_back();
    test_wrap();
    test_loop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
